// File: rtl/mul_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU engine with architectural HI/LO registers.
// Takes 32 iterations in RUN plus one sign-fixup edge in FIX. Asserts busy so the core stalls.
module mul_div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [1:0]  op,
    input  logic        start,
    input  logic        wrhi,
    input  logic        wrlo,
    input  logic [31:0] wrdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2} state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q;
    logic [31:0] hi_q, lo_q;
    logic        done_q;

    logic [1:0]  op_q;
    logic        bz_q, sa_q, sb_q;
    logic [31:0] a_raw_q, opnd_q;
    logic [63:0] acc_q, acc_d;

    logic [31:0] mag_a, mag_b;
    logic [32:0] add_sum;
    logic [31:0] trial;
    logic        borrow;
    logic        neg_q_res, neg_rem;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix, rem_fix;

    assign mag_a = (op[0] && a[31]) ? -a : a;
    assign mag_b = (op[0] && b[31]) ? -b : b;

    always_ff @(posedge clk) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (cnt_q == 6'd31) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != IDLE);
        done = done_q;
        hi   = hi_q;
        lo   = lo_q;
    end

    // One iteration: multiply adds the multiplicand on a set LSB then shifts right;
    // divide shifts remainder:quotient left and keeps the trial difference if no borrow.
    always_comb begin
        add_sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
        borrow  = (acc_q[63:31] < {1'b0, opnd_q});
        trial   = acc_q[62:31] - opnd_q;
        if (op_q[1])
            acc_d = borrow ? {acc_q[62:0], 1'b0} : {trial, acc_q[30:0], 1'b1};
        else
            acc_d = {add_sum, acc_q[31:1]};
    end

    always_comb begin
        neg_q_res = op_q[0] && (sa_q ^ sb_q);
        neg_rem   = op_q[0] && sa_q;
        prod_fix  = neg_q_res ? -acc_q : acc_q;
        quo_fix   = neg_q_res ? -acc_q[31:0] : acc_q[31:0];
        rem_fix   = neg_rem ? -acc_q[63:32] : acc_q[63:32];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q  <= 6'd0;
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
            done_q <= 1'b0;
        end else begin
            done_q <= (state_q == FIX);
            case (state_q)
                IDLE: begin
                    if (wrhi)  hi_q  <= wrdata;
                    if (wrlo)  lo_q  <= wrdata;
                    if (start) cnt_q <= 6'd0;
                end
                RUN: cnt_q <= cnt_q + 6'd1;
                FIX: begin
                    if (!op_q[1]) begin
                        hi_q <= prod_fix[63:32];
                        lo_q <= prod_fix[31:0];
                    end else if (bz_q) begin
                        hi_q <= a_raw_q;
                        lo_q <= 32'hFFFF_FFFF;
                    end else begin
                        hi_q <= rem_fix;
                        lo_q <= quo_fix;
                    end
                end
                default: ;
            endcase
        end
    end

    // Operand/accumulator registers need no reset: they are always loaded at acceptance.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && start) begin
            op_q    <= op;
            bz_q    <= (b == 32'd0);
            sa_q    <= a[31];
            sb_q    <= b[31];
            a_raw_q <= a;
            opnd_q  <= op[1] ? mag_b : mag_a;
            acc_q   <= {32'd0, op[1] ? mag_a : mag_b};
        end else if (state_q == RUN) begin
            acc_q   <= acc_d;
        end
    end
endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Multi-cycle multiply/divide unit beside the ArithmeticLogicUnit in the MIPS datapath. It takes the same two GPR operands the ALU receives and runs MULT, MULTU, DIV and DIVU with a 32-iteration shift-add or restoring-divide engine. Results go into architectural HI/LO registers, which the datapath reads for MFHI/MFLO. While an operation runs, the unit asserts busy so the decoder stalls the PC on any dependent instruction.

## Interface
- No parameters; data width fixed at 32.
- clk  in  1  rising-edge clock, the processor clock.
- reset  in  1  synchronous, active-low; sampled on the rising edge of clk.
- a  in  32  operand rs (multiplicand / dividend).
- b  in  32  operand rt (multiplier / divisor).
- op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- start  in  1  request; accepted only in IDLE.
- wrhi  in  1  MTHI strobe; writes wrdata to HI.
- wrlo  in  1  MTLO strobe; writes wrdata to LO.
- wrdata  in  32  data for MTHI/MTLO.
- busy  out  1  high from the cycle after acceptance until completion.
- done  out  1  one-cycle completion pulse.
- hi  out  32  HI register.
- lo  out  32  LO register.

## Operation
- States: IDLE, RUN, FIX.
- IDLE, start=1 at edge k:
  - latch op, b==0 flag and operand signs;
  - latch |a| and |b| for signed ops, raw a and b for unsigned ops;
  - clear 6-bit iteration counter; go to RUN.
- RUN: one iteration per edge, 32 edges.
  - Multiply: 64-bit accumulator with shift-add, one multiplier bit per iteration (LSB first).
  - Divide: restoring. Shift remainder:quotient left, trial-subtract divisor, set quotient bit if no borrow.
  - After the 32nd iteration, go to FIX.
- FIX (one edge): write hi/lo, pulse done, return to IDLE.
  - MULT: negate the 64-bit product if the operand signs differ.
  - DIV: negate the quotient if the signs differ; negate the remainder if the dividend was negative (truncate toward zero).
  - Multiply result: HI = product[63:32], LO = product[31:0].
  - Divide result: LO = quotient, HI = remainder.
- Divide by zero, signed or unsigned: LO = 32'hFFFFFFFF and HI = original a, raw and uncorrected. Sign correction is bypassed. Latency is unchanged.
- Signed overflow: DIV 32'h80000000 / 32'hFFFFFFFF gives LO = 32'h80000000, HI = 0 (two's-complement wrap, no trap).
- hi/lo hold their old values throughout RUN; intermediate values live only in internal registers.
- wrhi/wrlo:
  - honoured only in IDLE; takes effect on that edge;
  - both may be set in one cycle;
  - ignored while busy.
- start together with wrhi/wrlo in IDLE: the write is applied and the operation starts; completion later overwrites both HI and LO.
- start while busy (RUN/FIX): ignored, not queued.
- Operands are sampled only at acceptance; a and b may change freely afterwards.

## Timing
- Reset (reset=0 at an edge), from any state including mid-operation:
  - state goes to IDLE; counter cleared;
  - hi = 0, lo = 0, busy = 0, done = 0;
  - any in-flight result is discarded.
- Acceptance edge k; busy = 1 during cycles k+1 through k+33 (33 cycles).
- RUN covers edges k+1..k+32. The FIX edge k+33 updates hi/lo.
- After edge k+33: busy = 0 and done = 1 for exactly one cycle; hi/lo already hold the new values.
- A new start may be presented in the same cycle done is high; it is accepted at edge k+34. Back-to-back throughput is one operation per 34 cycles.
- done is 0 at all other times; busy never glitches mid-operation.
- hi/lo are registered outputs; MFHI/MFLO read them combinationally in the same cycle.

## Test plan
- Reset: hold reset=0 for 2 edges mid-RUN, then release -> hi=0, lo=0, busy=0, done=0; no done pulse follows.
- MULTU 32'hFFFFFFFF × 32'hFFFFFFFF -> after 33 busy cycles, done pulses once; hi=32'hFFFFFFFE, lo=32'h00000001.
- MULT -3 × 5 (32'hFFFFFFFD, 32'h00000005) -> hi=32'hFFFFFFFF, lo=32'hFFFFFFF1.
- DIVU 100/7 -> lo=32'h0000000E, hi=32'h00000002. DIV -7/2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF.
- DIV 32'hFFFFFFF9/0 -> lo=32'hFFFFFFFF, hi=32'hFFFFFFF9. DIV 32'h80000000/32'hFFFFFFFF -> lo=32'h80000000, hi=0.
- Handshake corner cases, in order:
  - in IDLE, wrhi with wrdata=32'h1234 -> hi=32'h1234 next cycle;
  - start DIVU 9/4; during busy, pulse start (DIVU 1/1) and wrlo -> both ignored;
  - at completion, lo=2 and hi=1;
  - start in the done cycle -> accepted at the next edge.
